// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: owns the PC, drives a req/valid imem handshake,
// skid-buffers one instruction across a decode stall and drops stale responses after a redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemRdata,
    input  logic        ImemValid,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchBusy
);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;

    logic        bubble, load;
    logic [31:0] ld_instr, ld_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            redir_q     <= '0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            instr_q     <= NOP_INSTR;
            pcd_q       <= '0;
            pcp4_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redir_q     <= redir_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            instr_q     <= instr_d;
            pcd_q       <= pcd_d;
            pcp4_q      <= pcp4_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_d     = redir_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        instr_d     = instr_q;
        pcd_d       = pcd_q;
        pcp4_d      = pcp4_q;
        valid_d     = valid_q;
        bubble      = 1'b0;
        load        = 1'b0;
        ld_instr    = ImemRdata;
        ld_pc       = pc_q;

        case (state_q)
            S_FETCH: begin
                if (PCSrcE) begin
                    // A response arriving with the redirect is already stale.
                    if (ImemValid) begin
                        pc_d = PCTargetE;
                    end else begin
                        redir_d = PCTargetE;
                        state_d = S_DRAIN;
                    end
                    bubble = !StallD;
                end else if (ImemValid && !StallD) begin
                    load = 1'b1;
                    pc_d = pc_q + 32'd4;
                end else if (ImemValid) begin
                    buf_instr_d = ImemRdata;
                    buf_pc_d    = pc_q;
                    state_d     = S_HOLD;
                end else begin
                    bubble = !StallD;
                end
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    pc_d    = PCTargetE;
                    state_d = S_FETCH;
                    bubble  = !StallD;
                end else if (!StallD) begin
                    load     = 1'b1;
                    ld_instr = buf_instr_q;
                    ld_pc    = buf_pc_q;
                    pc_d     = buf_pc_q + 32'd4;
                    state_d  = S_FETCH;
                end
            end
            S_DRAIN: begin
                bubble = !StallD;
                if (PCSrcE) redir_d = PCTargetE;
                // The newest redirect wins even when it lands with the stale response.
                if (ImemValid) begin
                    pc_d    = PCSrcE ? PCTargetE : redir_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (FlushD || bubble) begin
            instr_d = NOP_INSTR;
            pcd_d   = '0;
            pcp4_d  = '0;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = ld_instr;
            pcd_d   = ld_pc;
            pcp4_d  = ld_pc + 32'd4;
            valid_d = 1'b1;
        end
    end

    assign ImemReq   = !reset && (state_q != S_HOLD);
    assign FetchBusy = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign ImemAddr  = pc_q;
    assign PCF       = pc_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign PCPlus4D  = pcp4_q;
    assign ValidD    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Cycle-table bench for fetch_stage: the bench plays instruction memory and
// checks fetch-side outputs before each edge and IF/ID contents after it.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallD, FlushD, PCSrcE, ImemValid;
    logic [31:0] PCTargetE, ImemRdata;
    logic        ImemReq, ValidD, FetchBusy;
    logic [31:0] ImemAddr, PCF, InstrD, PCD, PCPlus4D;

    fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ImemReq(ImemReq),
        .ImemAddr(ImemAddr), .ImemRdata(ImemRdata), .ImemValid(ImemValid),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .FetchBusy(FetchBusy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st, fl, br;
        logic [31:0] tgt;
        logic        iv;
        logic        ereq;
        logic [31:0] epcf;
        logic        ev;
        logic [31:0] ei, epc, ep4;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] i, pc, p4;
    } ifid_t;

    vec_t  vt[30];
    ifid_t sb[$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [31:0] wfun(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        if (a == 32'h104) return 32'h00A0_0113;
        return a ^ 32'h1234_5013;
    endfunction

    // ev=0 rows describe a bubble; the PC+4 expectation follows from epc.
    function automatic vec_t V(input logic st, fl, br, input logic [31:0] tgt,
                               input logic iv, ereq, input logic [31:0] epcf,
                               input logic ev, input logic [31:0] epc);
        vec_t r;
        r.st = st; r.fl = fl; r.br = br; r.tgt = tgt; r.iv = iv;
        r.ereq = ereq; r.epcf = epcf; r.ev = ev;
        r.ei  = ev ? wfun(epc) : NOP;
        r.epc = ev ? epc : 32'h0;
        r.ep4 = ev ? epc + 32'd4 : 32'h0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        ifid_t e;
        //        st fl br tgt            iv req pcf           ev pcd
        vt[0]  = V(0, 0, 0, 32'h0,        1, 1, 32'h100,       1, 32'h100);
        vt[1]  = V(0, 0, 0, 32'h0,        1, 1, 32'h104,       1, 32'h104);
        vt[2]  = V(0, 0, 0, 32'h0,        0, 1, 32'h108,       0, 32'h0);
        vt[3]  = V(0, 0, 0, 32'h0,        0, 1, 32'h108,       0, 32'h0);
        vt[4]  = V(0, 0, 0, 32'h0,        1, 1, 32'h108,       1, 32'h108);
        vt[5]  = V(1, 0, 0, 32'h0,        1, 1, 32'h10C,       1, 32'h108);
        vt[6]  = V(1, 0, 0, 32'h0,        0, 0, 32'h10C,       1, 32'h108);
        vt[7]  = V(1, 0, 0, 32'h0,        0, 0, 32'h10C,       1, 32'h108);
        vt[8]  = V(0, 0, 0, 32'h0,        0, 0, 32'h10C,       1, 32'h10C);
        vt[9]  = V(0, 0, 0, 32'h0,        1, 1, 32'h110,       1, 32'h110);
        vt[10] = V(0, 0, 0, 32'h0,        0, 1, 32'h114,       0, 32'h0);
        vt[11] = V(0, 0, 1, 32'h200,      0, 1, 32'h114,       0, 32'h0);
        vt[12] = V(0, 0, 0, 32'h0,        0, 1, 32'h114,       0, 32'h0);
        vt[13] = V(0, 0, 0, 32'h0,        1, 1, 32'h114,       0, 32'h0);
        vt[14] = V(0, 0, 0, 32'h0,        1, 1, 32'h200,       1, 32'h200);
        vt[15] = V(1, 1, 0, 32'h0,        1, 1, 32'h204,       0, 32'h0);
        vt[16] = V(0, 0, 0, 32'h0,        0, 0, 32'h204,       1, 32'h204);
        vt[17] = V(0, 1, 1, 32'hFFFFFFFC, 1, 1, 32'h208,       0, 32'h0);
        vt[18] = V(0, 0, 0, 32'h0,        1, 1, 32'hFFFFFFFC,  1, 32'hFFFFFFFC);
        vt[19] = V(0, 0, 0, 32'h0,        0, 1, 32'h0,         0, 32'h0);
        vt[20] = V(1, 0, 0, 32'h0,        1, 1, 32'h0,         0, 32'h0);
        vt[21] = V(1, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0);
        vt[22] = V(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0);
        vt[23] = V(1, 0, 0, 32'h0,        1, 1, 32'h4,         1, 32'h0);
        vt[24] = V(0, 1, 1, 32'h300,      0, 0, 32'h4,         0, 32'h0);
        vt[25] = V(0, 0, 0, 32'h0,        1, 1, 32'h300,       1, 32'h300);
        vt[26] = V(0, 0, 1, 32'h400,      0, 1, 32'h304,       0, 32'h0);
        vt[27] = V(1, 0, 1, 32'h500,      0, 1, 32'h304,       0, 32'h0);
        vt[28] = V(0, 0, 0, 32'h0,        1, 1, 32'h304,       0, 32'h0);
        vt[29] = V(0, 0, 0, 32'h0,        1, 1, 32'h500,       1, 32'h500);

        reset = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = '0; ImemValid = 1'b0; ImemRdata = 32'hDEAD_BEEF;
        #2;
        chk("rst_req",    {31'b0, ImemReq}, 32'h0);
        chk("rst_pcf",    PCF,    RPC);
        chk("rst_instr",  InstrD, NOP);
        chk("rst_pcd",    PCD,    32'h0);
        chk("rst_pcp4",   PCPlus4D, 32'h0);
        chk("rst_valid",  {31'b0, ValidD}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 30; k++) begin
            if (k > 0) @(negedge clk);
            StallD    = vt[k].st;
            FlushD    = vt[k].fl;
            PCSrcE    = vt[k].br;
            PCTargetE = vt[k].tgt;
            ImemValid = vt[k].iv;
            ImemRdata = vt[k].iv ? wfun(vt[k].epcf) : 32'hDEAD_BEEF;
            #2;
            chk($sformatf("r%0d_req", k),  {31'b0, ImemReq},   {31'b0, vt[k].ereq});
            chk($sformatf("r%0d_busy", k), {31'b0, FetchBusy}, {31'b0, vt[k].ereq});
            chk($sformatf("r%0d_pcf", k),  PCF, vt[k].epcf);
            if (vt[k].ereq) chk($sformatf("r%0d_addr", k), ImemAddr, vt[k].epcf);
            e.v = vt[k].ev; e.i = vt[k].ei; e.pc = vt[k].epc; e.p4 = vt[k].ep4;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("r%0d_instr", k), InstrD,   e.i);
            chk($sformatf("r%0d_pcd", k),   PCD,      e.pc);
            chk($sformatf("r%0d_pcp4", k),  PCPlus4D, e.p4);
            chk($sformatf("r%0d_valid", k), {31'b0, ValidD}, {31'b0, e.v});
        end

        // Asynchronous reset mid-cycle must take effect without a clock edge.
        @(negedge clk);
        StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; ImemValid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req",   {31'b0, ImemReq}, 32'h0);
        chk("arst_pcf",   PCF,    RPC);
        chk("arst_instr", InstrD, NOP);
        chk("arst_pcd",   PCD,    32'h0);
        chk("arst_valid", {31'b0, ValidD}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
